pixel_mem_slave: RTL and testbench

Memory-side AHB-Lite-style slave that terminates the accelerator's master port: it answers `m_haddr`/`m_hwrite`/`m_hwdata` with `m_hrdata`/`m_hready` from an internal 32-bit word memory, inserting a programmable number of wait states. It sits directly downstream of the top-level edge-detection system. It is the source of RGB pixel reads and the sink of processed-result writes, both in system simulation and in FPGA bring-up.

---
 rtl/pixel_mem_pkg.sv | 22 ++
 rtl/pixel_mem_if.sv | 22 ++
 rtl/pixel_mem_array.sv | 34 +++
 rtl/pixel_mem_slave.sv | 173 +++++++++++++++++
 tb/tb_pixel_mem_slave.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_mem_pkg.sv
// pixel_mem_pkg: shared types and constants for the pixel memory slave.
package pixel_mem_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LAST = 2'd2
    } pm_state_t;

    localparam int PM_CNT_W = 16;
    localparam int PM_WS_W  = 4;

    // An address is bad if it points beyond the memory or is not word aligned.
    function automatic logic pm_addr_err(input word_t addr, input int addr_w);
        word_t hi;
        hi = addr >> (addr_w + 2);
        return (hi != '0) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pixel_mem_if.sv
// pixel_mem_if: AHB-Lite-style bus between the accelerator master port and the memory slave.
interface pixel_mem_if;
    import pixel_mem_pkg::*;

    logic  i_hsel;
    word_t m_haddr;
    logic  m_hwrite;
    word_t m_hwdata;
    word_t m_hrdata;
    logic  m_hready;

    modport master (
        output i_hsel, m_haddr, m_hwrite, m_hwdata,
        input  m_hrdata, m_hready
    );

    modport slave (
        input  i_hsel, m_haddr, m_hwrite, m_hwdata,
        output m_hrdata, m_hready
    );

endinterface

// File: rtl/pixel_mem_array.sv
// pixel_mem_array: word RAM on one clock with a write port and a registered
// read port, kept free of reset so it maps onto block RAM.
module pixel_mem_array
    import pixel_mem_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  word_t             wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output word_t             rdata
);

    word_t mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value between read enables.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pixel_mem_slave.sv
// pixel_mem_slave: memory-side bus slave with programmable wait states.
// Define PIXEL_MEM_ERR_EN to add range/alignment checking and the sticky o_err port.
module pixel_mem_slave
    import pixel_mem_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    pixel_mem_if.slave          bus,
    output logic [PM_CNT_W-1:0] o_rd_count,
    output logic [PM_CNT_W-1:0] o_wr_count
`ifdef PIXEL_MEM_ERR_EN
    ,
    output logic                o_err
`endif
);

    localparam int                 ADDR_W = $clog2(DEPTH);
    localparam logic [PM_WS_W-1:0] WS     = PM_WS_W'(WAIT_STATES);

    pm_state_t           state_reg, state_next;
    logic [PM_WS_W-1:0]  cnt_reg, cnt_next;
    word_t               addr_reg;
    logic                write_reg;
    logic                rd_zero_reg;
    logic                fwd_valid_reg;
    word_t               fwd_data_reg;
    logic [PM_CNT_W-1:0] count_reg [2];

    logic              accept;
    logic              enter_last;
    logic              complete;
    word_t             cur_addr;
    logic              cur_write;
    logic [ADDR_W-1:0] cur_idx;
    logic [ADDR_W-1:0] done_idx;
    logic              cur_err;
    logic              done_err;
    logic              wr_commit;
    logic              rd_load;
    logic              fwd_hit;
    word_t             ram_q;

    assign bus.m_hready = (state_reg != WAIT);
    assign accept       = bus.m_hready && bus.i_hsel;
    assign complete     = (state_reg == LAST);

    // Next-state logic: wait-state countdown and pipelined accept out of LAST.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE, LAST: begin
                if (accept) begin
                    if (WS != '0) begin
                        state_next = WAIT;
                        cnt_next   = WS;
                    end else begin
                        state_next = LAST;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == PM_WS_W'(1)) begin
                    state_next = LAST;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, countdown and address-phase capture.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            write_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg  <= bus.m_haddr;
                write_reg <= bus.m_hwrite;
            end
        end
    end

    // The transfer entering LAST comes from the captured address after wait
    // states, or straight from the bus when there are none.
    assign enter_last = (state_next == LAST);
    assign cur_addr   = (state_reg == WAIT) ? addr_reg  : bus.m_haddr;
    assign cur_write  = (state_reg == WAIT) ? write_reg : bus.m_hwrite;
    assign cur_idx    = cur_addr[ADDR_W+1:2];
    assign done_idx   = addr_reg[ADDR_W+1:2];

`ifdef PIXEL_MEM_ERR_EN
    assign cur_err  = pm_addr_err(cur_addr, ADDR_W);
    assign done_err = pm_addr_err(addr_reg, ADDR_W);
`else
    assign cur_err  = 1'b0;
    assign done_err = 1'b0;
    // Upper and byte-offset address bits are deliberately ignored (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cur_addr[31:ADDR_W+2], cur_addr[1:0],
                                addr_reg[31:ADDR_W+2], addr_reg[1:0]};
`endif

    assign wr_commit = complete && write_reg && !done_err;
    assign rd_load   = enter_last && !cur_write;
    // A write retiring on the same edge a read of that word loads must win over the RAM.
    assign fwd_hit   = wr_commit && (done_idx == cur_idx);

    pixel_mem_array #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (wr_commit),
        .waddr(done_idx),
        .wdata(bus.m_hwdata),
        .re   (rd_load && !cur_err && !fwd_hit),
        .raddr(cur_idx),
        .rdata(ram_q)
    );

    // Read-data source select: zero after reset or on a bad read, forwarded write data, or RAM.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_zero_reg   <= 1'b1;
            fwd_valid_reg <= 1'b0;
            fwd_data_reg  <= '0;
        end else if (rd_load) begin
            rd_zero_reg   <= cur_err;
            fwd_valid_reg <= fwd_hit;
            fwd_data_reg  <= bus.m_hwdata;
        end
    end

    assign bus.m_hrdata = rd_zero_reg   ? '0 :
                          fwd_valid_reg ? fwd_data_reg : ram_q;

    // Completion counters, index 0 for reads and 1 for writes, saturating at all-ones.
    for (genvar gi = 0; gi < 2; gi++) begin : g_count
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                count_reg[gi] <= '0;
            end else if (complete && (write_reg == 1'(gi)) && (count_reg[gi] != '1)) begin
                count_reg[gi] <= count_reg[gi] + 1'b1;
            end
        end
    end

    assign o_rd_count = count_reg[0];
    assign o_wr_count = count_reg[1];

`ifdef PIXEL_MEM_ERR_EN
    // Sticky error flag, set when a bad access retires.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_err <= 1'b0;
        end else if (complete && done_err) begin
            o_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_mem_slave.sv
// tb_pixel_mem_slave: two slaves (2 and 0 wait states) driven with directed and
// random transfers, checked against a transaction-level memory model.
module tb_pixel_mem_slave;
    import pixel_mem_pkg::*;

    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    pixel_mem_if bus_a ();
    pixel_mem_if bus_b ();

    logic [15:0] rd_a, wr_a, rd_b, wr_b;
`ifdef PIXEL_MEM_ERR_EN
    logic err_a, err_b;
`endif

    pixel_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .n_rst(n_rst), .bus(bus_a), .o_rd_count(rd_a), .o_wr_count(wr_a)
`ifdef PIXEL_MEM_ERR_EN
        , .o_err(err_a)
`endif
    );

    pixel_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .n_rst(n_rst), .bus(bus_b), .o_rd_count(rd_b), .o_wr_count(wr_b)
`ifdef PIXEL_MEM_ERR_EN
        , .o_err(err_b)
`endif
    );

    typedef struct {
        bit    wr;
        word_t addr;
        word_t data;
    } op_t;

    int          checks = 0;
    int          errors = 0;
    op_t         ops[$];
    word_t       model_mem [2][DEPTH];
    bit          known     [2][DEPTH];
    int unsigned model_rd  [2];
    int unsigned model_wr  [2];
    bit          model_err [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_bad(input word_t a);
`ifdef PIXEL_MEM_ERR_EN
        return (a >= 32'(DEPTH * 4)) || ((a % 4) != 0);
`else
        return (a != a);
`endif
    endfunction

    function automatic int widx(input word_t a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic logic get_ready(input int d);
        return (d == 0) ? bus_a.m_hready : bus_b.m_hready;
    endfunction

    function automatic word_t get_rdata(input int d);
        return (d == 0) ? bus_a.m_hrdata : bus_b.m_hrdata;
    endfunction

    function automatic logic [15:0] get_rd(input int d);
        return (d == 0) ? rd_a : rd_b;
    endfunction

    function automatic logic [15:0] get_wr(input int d);
        return (d == 0) ? wr_a : wr_b;
    endfunction

`ifdef PIXEL_MEM_ERR_EN
    function automatic logic get_err(input int d);
        return (d == 0) ? err_a : err_b;
    endfunction
`endif

    task automatic drive(input int d, input logic sel, input logic wr, input word_t addr);
        if (d == 0) begin
            bus_a.i_hsel = sel; bus_a.m_hwrite = wr; bus_a.m_haddr = addr;
        end else begin
            bus_b.i_hsel = sel; bus_b.m_hwrite = wr; bus_b.m_haddr = addr;
        end
    endtask

    task automatic drive_wdata(input int d, input word_t w);
        if (d == 0) bus_a.m_hwdata = w;
        else        bus_b.m_hwdata = w;
    endtask

    task automatic check_counts(input int d, input string tag);
        check({tag, "_rd_count"}, 32'(get_rd(d)), model_rd[d]);
        check({tag, "_wr_count"}, 32'(get_wr(d)), model_wr[d]);
`ifdef PIXEL_MEM_ERR_EN
        check({tag, "_err"}, 32'(get_err(d)), 32'(model_err[d]));
`endif
    endtask

    // Issue every queued op back to back on DUT d and check each at its LAST cycle.
    task automatic run_ops(input int d);
        int  ws;
        int  ix;
        op_t op;
        ws = (d == 0) ? 2 : 0;
        while (ops.size() > 0) begin
            op = ops.pop_front();
            drive(d, 1'b1, op.wr, op.addr);
            @(posedge clk); #1;
            drive_wdata(d, op.data);
            for (int k = 0; k < ws; k++) begin
                check($sformatf("d%0d_wait_ready_%0d", d, k), 32'(get_ready(d)), 32'd0);
                @(posedge clk); #1;
            end
            check($sformatf("d%0d_last_ready", d), 32'(get_ready(d)), 32'd1);
            ix = widx(op.addr);
            if (addr_bad(op.addr)) begin
                model_err[d] = 1'b1;
                if (!op.wr) check($sformatf("d%0d_rdata_bad@%h", d, op.addr), get_rdata(d), 32'd0);
            end else if (op.wr) begin
                model_mem[d][ix] = op.data;
                known[d][ix]     = 1'b1;
            end else if (known[d][ix]) begin
                check($sformatf("d%0d_rdata@%h", d, op.addr), get_rdata(d), model_mem[d][ix]);
            end
            if (op.wr) begin
                if (model_wr[d] < 65535) model_wr[d]++;
            end else begin
                if (model_rd[d] < 65535) model_rd[d]++;
            end
            $display("xfer d%0d %s addr=%h data=%h rdata=%h", d, op.wr ? "WR" : "RD",
                     op.addr, op.data, get_rdata(d));
        end
        drive(d, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
    endtask

    task automatic push(input bit wr, input word_t addr, input word_t data);
        op_t op;
        op.wr = wr; op.addr = addr; op.data = data;
        ops.push_back(op);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int    bad;
        word_t a;
        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, 1'b0, '0);
            drive_wdata(d, '0);
            model_rd[d] = 0; model_wr[d] = 0; model_err[d] = 1'b0;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_reset_ready", d), 32'(get_ready(d)), 32'd1);
            check($sformatf("d%0d_reset_rdata", d), get_rdata(d), 32'd0);
            check_counts(d, $sformatf("d%0d_reset", d));
        end
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Write then read with two wait states.
        push(1'b1, 32'h10, 32'hDEADBEEF);
        push(1'b0, 32'h10, 32'h0);
        run_ops(0);
        check_counts(0, "ws2_wr_rd");

        // Forwarding with zero wait states: stale value first, then write+read back to back.
        push(1'b1, 32'h20, 32'h0BADF00D);
        run_ops(1);
        push(1'b1, 32'h20, 32'h12345678);
        push(1'b0, 32'h20, 32'h0);
        run_ops(1);
        check_counts(1, "ws0_fwd");

        // Out-of-range read: wraps to word 0 normally, errors when checking is built in.
        push(1'b1, 32'h0, 32'hCAFEF00D);
        push(1'b0, 32'h4000, 32'h0);
        push(1'b0, 32'h10, 32'h0);
        run_ops(0);
        check_counts(0, "range");

        // Reset during the WAIT of a write: write dropped, prior contents kept.
        push(1'b1, 32'h40, 32'h11112222);
        run_ops(0);
        drive(0, 1'b1, 1'b1, 32'h40);
        @(posedge clk); #1;
        drive_wdata(0, 32'hAAAA5555);
        check("mt_in_wait", 32'(get_ready(0)), 32'd0);
        #2 n_rst = 1'b0;
        #1;
        drive(0, 1'b0, 1'b0, '0);
        for (int d = 0; d < 2; d++) begin
            model_rd[d] = 0; model_wr[d] = 0; model_err[d] = 1'b0;
            check($sformatf("d%0d_mt_ready", d), 32'(get_ready(d)), 32'd1);
            check($sformatf("d%0d_mt_rdata", d), get_rdata(d), 32'd0);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        push(1'b0, 32'h40, 32'h0);
        run_ops(0);
        check_counts(0, "mt_after");

        // Random back-to-back traffic over a small pool, with wrap/misaligned variants.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) push(1'b1, 32'h100 + 32'(4 * i), $urandom);
            for (int i = 0; i < 40; i++) begin
                a = 32'h100 + 32'(4 * $urandom_range(0, 7));
                if ($urandom_range(0, 7) == 0) a = a + 32'h4000;
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
                push(1'($urandom_range(0, 1)), a, $urandom);
            end
            run_ops(d);
            check_counts(d, $sformatf("d%0d_rand", d));
        end

        // Read counter saturation with continuous zero-wait reads.
        bad = 0;
        drive(1, 1'b1, 1'b0, 32'h20);
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk); #1;
            if (get_ready(1) !== 1'b1) bad++;
        end
        drive(1, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        $display("xfer d1 RD x65540 addr=00000020 rd_count=%h", get_rd(1));
        check("sat_cadence_stalls", 32'(bad), 32'd0);
        check("sat_rdata", get_rdata(1), model_mem[1][widx(32'h20)]);
        model_rd[1] = 65535;
        check_counts(1, "sat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
